// File: rtl/pq_arb_pkg.sv
// pq_arb_pkg: op encodings, FSM states and response codes for the
// priority-queue client arbiter.
package pq_arb_pkg;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_TOP  = 2'b11;
    typedef enum logic [2:0] {IDLE, PUSH, POP_WAIT, TOP_WAIT, RESP} state_t;
    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;
endpackage

// File: rtl/pq_client_arbiter_rr.sv
// rr_arbiter: one-hot round-robin grant, first requester at or above the pointer.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);
    logic          w_found;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_k;
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            w_k   = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end
endmodule

// File: rtl/pq_client_arbiter.sv
// pq_client_arbiter: shares one max priority queue among NUM_CLIENTS
// requesters, tracking occupancy so empty/full requests never stall.
module pq_client_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int PQ_DEPTH    = 8,
    parameter int TIMEOUT     = 32,
    localparam int IW = $clog2(NUM_CLIENTS),
    localparam int OW = $clog2(PQ_DEPTH+1),
    localparam int WW = $clog2(TIMEOUT+1)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_CLIENTS-1:0]            i_req_valid,
    input  logic [2*NUM_CLIENTS-1:0]          i_req_op,
    input  logic [DATA_WIDTH*NUM_CLIENTS-1:0] i_req_data,
    output logic [NUM_CLIENTS-1:0]            o_req_ready,
    output logic [NUM_CLIENTS-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]             o_rsp_data,
    output logic                              o_rsp_err,
    output logic [1:0]                        o_pq_op,
    output logic [DATA_WIDTH-1:0]             o_pq_data,
    output logic                              o_pq_valid_in,
    output logic                              o_pq_ready_in,
    input  logic                              i_pq_ready_out,
    input  logic [DATA_WIDTH-1:0]             i_pq_out,
    input  logic                              i_pq_valid_out,
    output logic [OW-1:0]                     o_occupancy
);
    state_t                  r_state, w_next;
    logic [IW-1:0]           r_ptr, w_idx, w_ptr_nxt;
    logic [NUM_CLIENTS-1:0]  r_gnt, w_grant;
    logic [DATA_WIDTH-1:0]   r_data, r_rsp_data, w_data;
    logic                    r_rsp_err;
    logic [OW-1:0]           r_occ;
    logic [WW-1:0]           r_wait;
    logic [1:0]              w_op;
    logic [1:0]              w_ops [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]   w_datas [NUM_CLIENTS];
    logic                    w_any, w_full, w_empty, w_accept, w_timeout;
    for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_unpack
        assign w_ops[c]   = i_req_op[2*c +: 2];
        assign w_datas[c] = i_req_data[DATA_WIDTH*c +: DATA_WIDTH];
    end
    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );
    assign w_any       = |i_req_valid;
    assign w_op        = w_ops[w_idx];
    assign w_data      = w_datas[w_idx];
    assign w_full      = r_occ == OW'(PQ_DEPTH);
    assign w_empty     = r_occ == '0;
    assign w_ptr_nxt   = (w_idx == IW'(NUM_CLIENTS-1)) ? '0 : w_idx + 1'b1;
    assign o_occupancy = r_occ;
    assign o_rsp_valid = (r_state == RESP) ? r_gnt : '0;
    assign o_rsp_data  = (r_state == RESP) ? r_rsp_data : '0;
    assign o_rsp_err   = (r_state == RESP) && r_rsp_err;
    always_comb begin
        w_next        = r_state;
        o_req_ready   = '0;
        o_pq_op       = OP_NOP;
        o_pq_data     = '0;
        o_pq_valid_in = 1'b0;
        o_pq_ready_in = 1'b0;
        w_accept      = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            IDLE: if (w_any) begin
                o_req_ready = w_grant;
                w_next = (w_op == OP_PUSH && !w_full) ? PUSH :
                         (w_op == OP_POP  && !w_empty) ? POP_WAIT :
                         (w_op == OP_TOP  && !w_empty) ? TOP_WAIT : RESP;
            end
            PUSH: begin
                o_pq_op       = OP_PUSH;
                o_pq_valid_in = 1'b1;
                o_pq_data     = r_data;
                w_next        = RESP;
            end
            POP_WAIT, TOP_WAIT: begin
                w_accept      = i_pq_valid_out;
                w_timeout     = !i_pq_valid_out && r_wait == WW'(TIMEOUT-1);
                o_pq_op       = w_timeout ? OP_NOP : (r_state == POP_WAIT) ? OP_POP : OP_TOP;
                o_pq_ready_in = !w_timeout;
                w_next        = (w_accept || w_timeout) ? RESP : r_state;
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= RSP_OK;
            r_occ      <= '0;
            r_wait     <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: if (w_any) begin
                    r_gnt      <= w_grant;
                    r_data     <= w_data;
                    r_ptr      <= w_ptr_nxt;
                    r_wait     <= '0;
                    r_rsp_data <= '0;
                    r_rsp_err  <= (w_next == RESP && w_op != OP_NOP) ? RSP_ERR : RSP_OK;
                end
                PUSH: begin
                    r_rsp_data <= r_data;
                    r_rsp_err  <= i_pq_ready_out ? RSP_OK : RSP_ERR;
                    r_occ      <= r_occ + OW'(i_pq_ready_out);
                end
                POP_WAIT, TOP_WAIT: begin
                    r_wait <= r_wait + 1'b1;
                    if (w_accept) begin
                        r_rsp_data <= i_pq_out;
                        r_rsp_err  <= RSP_OK;
                        if (r_state == POP_WAIT) r_occ <= r_occ - 1'b1;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= RSP_ERR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pq_client_arbiter.sv
// tb_pq_client_arbiter: directed self-checking bench with a behavioural max-queue model.
module tb_pq_client_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready, rsp_valid;
    logic [7:0]  rsp_data, pq_data, pq_out;
    logic        rsp_err, pq_valid_in, pq_ready_in, pq_ready_out, pq_valid_out;
    logic [1:0]  pq_op;
    logic [3:0]  occupancy;
    int passed = 0, total = 0;
    int lat;
    logic [7:0] got_data;
    logic       got_err;
    logic pop_seen, vin_seen, rsp_seen, onehot_bad, hold;
    logic [7:0] q [8];
    int n, cnt, mi;
    logic vo;

    always #5 clk = ~clk;

    pq_client_arbiter dut (
        .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .i_req_op(req_op),
        .i_req_data(req_data), .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_pq_op(pq_op), .o_pq_data(pq_data),
        .o_pq_valid_in(pq_valid_in), .o_pq_ready_in(pq_ready_in), .i_pq_ready_out(pq_ready_out),
        .i_pq_out(pq_out), .i_pq_valid_out(pq_valid_out), .o_occupancy(occupancy)
    );

    // Queue model: result valid two cycles after ready_in rises; hold blocks it.
    assign pq_valid_out = vo;
    assign pq_ready_out = n < 8;
    always_comb begin
        mi = 0;
        for (int i = 1; i < 8; i++) if (i < n && q[i] > q[mi]) mi = i;
        pq_out = (n > 0) ? q[mi] : 8'd0;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0; cnt <= 0; vo <= 1'b0;
        end else begin
            cnt <= pq_ready_in ? cnt + 1 : 0;
            vo  <= pq_ready_in && cnt == 1 && !vo && !hold;
            if (pq_valid_in && pq_op == 2'b01 && n < 8) begin
                q[n] <= pq_data; n <= n + 1;
            end else if (vo && pq_ready_in && pq_op == 2'b10) begin
                q[mi] <= q[n-1]; n <= n - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (pq_op == 2'b10) pop_seen = 1'b1;
        if (pq_valid_in) vin_seen = 1'b1;
        if (|rsp_valid) rsp_seen = 1'b1;
        if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) onehot_bad = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic req(input int c, input logic [1:0] op, input logic [7:0] d);
        int k;
        @(negedge clk);
        req_valid[c] = 1'b1; req_op[2*c +: 2] = op; req_data[8*c +: 8] = d;
        #1;
        k = 0;
        while (!req_ready[c] && k < 50) begin @(negedge clk); #1; k++; end
        check("grant", {31'd0, req_ready[c]}, 1);
        @(negedge clk);
        req_valid[c] = 1'b0;
        lat = 1;
        while (!rsp_valid[c] && lat < 60) begin @(negedge clk); lat++; end
        got_data = rsp_data; got_err = rsp_err;
    endtask

    task automatic grants(input int first, input int last);
        int k;
        @(negedge clk);
        for (int c = first; c <= last; c++) begin
            req_valid[c] = 1'b1; req_op[2*c +: 2] = 2'b01; req_data[8*c +: 8] = 8'((c + 1) * 10);
        end
        for (int c = first; c <= last; c++) begin
            #1;
            k = 0;
            while (req_ready == 4'd0 && k < 20) begin @(negedge clk); #1; k++; end
            check("grant_order", {28'd0, req_ready}, 32'd1 << c);
            @(negedge clk);
            req_valid[c] = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        hold = 1'b0; pop_seen = 1'b0; vin_seen = 1'b0; rsp_seen = 1'b0; onehot_bad = 1'b0;
        #1;
        check("rst_ready", {28'd0, req_ready}, 0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 0);
        check("rst_occ", {28'd0, occupancy}, 0);
        check("rst_pq_op", {30'd0, pq_op}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Single client: push 5, 9, 3 then pop in priority order.
        req(0, 2'b01, 8'd5);
        check("push_lat", lat, 2);
        check("push_data", {24'd0, got_data}, 5);
        check("push_err", {31'd0, got_err}, 0);
        req(0, 2'b01, 8'd9);
        req(0, 2'b01, 8'd3);
        check("occ3", {28'd0, occupancy}, 3);
        req(0, 2'b10, 8'd0);
        check("pop1", {24'd0, got_data}, 9);
        check("pop1_err", {31'd0, got_err}, 0);
        req(0, 2'b10, 8'd0);
        check("pop2", {24'd0, got_data}, 5);
        req(0, 2'b10, 8'd0);
        check("pop3", {24'd0, got_data}, 3);
        check("pop3_err", {31'd0, got_err}, 0);
        check("occ0", {28'd0, occupancy}, 0);
        // Empty POP right after reset.
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        pop_seen = 1'b0;
        req(3, 2'b10, 8'd0);
        check("empty_lat", lat, 1);
        check("empty_err", {31'd0, got_err}, 1);
        check("empty_data", {24'd0, got_data}, 0);
        check("empty_no_pop", {31'd0, pop_seen}, 0);
        // Four concurrent pushes granted 0..3, then TOP.
        grants(0, 3);
        check("occ4", {28'd0, occupancy}, 4);
        req(2, 2'b11, 8'd0);
        check("top_data", {24'd0, got_data}, 40);
        check("top_err", {31'd0, got_err}, 0);
        check("top_occ", {28'd0, occupancy}, 4);
        // Fill to capacity, then overflow push.
        req(0, 2'b01, 8'd1);
        req(0, 2'b01, 8'd2);
        req(0, 2'b01, 8'd8);
        req(0, 2'b01, 8'd6);
        check("occ8", {28'd0, occupancy}, 8);
        vin_seen = 1'b0;
        req(0, 2'b01, 8'd7);
        check("full_err", {31'd0, got_err}, 1);
        check("full_data", {24'd0, got_data}, 0);
        check("full_no_vin", {31'd0, vin_seen}, 0);
        check("full_occ", {28'd0, occupancy}, 8);
        // Timeout with the queue never answering.
        hold = 1'b1;
        req(0, 2'b10, 8'd0);
        hold = 1'b0;
        check("to_lat", {31'd0, lat >= 32 && lat <= 34}, 1);
        check("to_err", {31'd0, got_err}, 1);
        check("to_data", {24'd0, got_data}, 0);
        check("to_occ", {28'd0, occupancy}, 8);
        // Reset during POP_WAIT.
        @(negedge clk);
        req_valid[2] = 1'b1; req_op[5:4] = 2'b10;
        #1;
        check("rw_grant", {28'd0, req_ready}, 4);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("rw_waiting", {31'd0, pq_ready_in}, 1);
        rsp_seen = 1'b0;
        rst = 1'b1;
        #1;
        check("rw_ready", {28'd0, req_ready}, 0);
        check("rw_rsp_valid", {28'd0, rsp_valid}, 0);
        check("rw_rsp_data", {24'd0, rsp_data}, 0);
        check("rw_rsp_err", {31'd0, rsp_err}, 0);
        check("rw_pq_op", {30'd0, pq_op}, 0);
        check("rw_pq_ready_in", {31'd0, pq_ready_in}, 0);
        check("rw_pq_valid_in", {31'd0, pq_valid_in}, 0);
        check("rw_pq_data", {24'd0, pq_data}, 0);
        check("rw_occ", {28'd0, occupancy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rw_no_rsp", {31'd0, rsp_seen}, 0);
        grants(0, 1);
        check("rw_occ2", {28'd0, occupancy}, 2);
        check("onehot", {31'd0, onehot_bad}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pq_client_arbiter.md
Name: pq_client_arbiter

Overview:
- Shares one max_priority_queue instance among NUM_CLIENTS requesters.
- Each client issues PUSH, POP or TOP requests with a valid/ready handshake. The block grants one request at a time in round-robin order and sequences the queue's op/valid_in/ready_in controls.
- It waits out the queue's result-settle latency, then returns a one-cycle response to the granting client.
- It keeps its own occupancy count, so POP/TOP on an empty queue and PUSH on a full queue never stall.

Parameters:
- NUM_CLIENTS, 4, number of requesters (at least 2).
- DATA_WIDTH, 8, element width; must match the queue.
- PQ_DEPTH, 8, queue capacity; must match the queue.
- TIMEOUT, 32, maximum cycles to wait for pq_valid_out before reporting an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CLIENTS  per-client request valid
- req_op  in  2*NUM_CLIENTS  per-client op; 00 NOP, 01 PUSH, 10 POP, 11 TOP
- req_data  in  DATA_WIDTH*NUM_CLIENTS  per-client push data
- req_ready  out  NUM_CLIENTS  one-hot accept pulse
- rsp_valid  out  NUM_CLIENTS  one-hot response pulse
- rsp_data  out  DATA_WIDTH  response value, shared by all clients
- rsp_err  out  1  set for: empty POP/TOP, full PUSH, timeout
- pq_op  out  2  to queue op
- pq_data  out  DATA_WIDTH  to queue data_in
- pq_valid_in  out  1  to queue valid_in
- pq_ready_in  out  1  to queue ready_in
- pq_ready_out  in  1  from queue ready_out
- pq_out  in  DATA_WIDTH  from queue pq_out
- pq_valid_out  in  1  from queue valid_out
- occupancy  out  $clog2(PQ_DEPTH+1)  current element count

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; round-robin pointer goes to 0; occupancy goes to 0.
  - All outputs go to 0. pq_op=NOP.
  - Any in-flight request is dropped with no response.
- State machine states: IDLE, PUSH, POP_WAIT, TOP_WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick grant g as the first requester at or above the round-robin pointer, with wraparound.
  - req_ready[g]=1 combinationally in that same cycle.
  - Latch op, data and g. Set pointer to g+1 mod NUM_CLIENTS.
  - Next state:
    - PUSH, if op=PUSH and occupancy<PQ_DEPTH.
    - POP_WAIT or TOP_WAIT, if op is POP or TOP and occupancy>0.
    - Otherwise RESP with rsp_err=1 and rsp_data=0.
    - NOP goes to RESP with rsp_err=0 and rsp_data=0.
- PUSH (exactly 1 cycle):
  - Drive pq_op=01, pq_valid_in=1, pq_data=latched data.
  - pq_ready_out is guaranteed high because occupancy<PQ_DEPTH. Occupancy increments by 1.
  - Next state RESP, rsp_data=latched data, rsp_err=0.
- POP_WAIT:
  - Drive pq_op=10 and pq_ready_in=1 every cycle.
  - The first cycle with pq_valid_out=1 is the pop-accept cycle. Capture pq_out into rsp_data, decrement occupancy, go to RESP.
- TOP_WAIT:
  - Same as POP_WAIT but pq_op=11 and no occupancy change.
- Timeout:
  - A wait counter clears on entry to POP_WAIT or TOP_WAIT.
  - When it reaches TIMEOUT: go to RESP with rsp_err=1, drive pq_op=NOP, leave occupancy unchanged.
- RESP (exactly 1 cycle):
  - rsp_valid[g]=1. All pq_* outputs are 0.
  - Next state IDLE. A new grant is possible on the following cycle.
- Latency:
  - PUSH: grant to response is 2 cycles.
  - POP/TOP: 1 + queue settle time (up to about $clog2(PQ_DEPTH)+2 cycles after the previous push/pop) + 1.
- req_ready is 0 in every state except IDLE. At most one bit of req_ready and of rsp_valid is high at any time.
- Clients must hold req_valid, req_op and req_data stable until req_ready.
- rsp_data and rsp_err are valid only while some rsp_valid bit is high; otherwise they hold 0.
- pq_op=NOP in IDLE and RESP.
- Occupancy never wraps: it saturates by construction at 0 and PQ_DEPTH.

Decomposition:
- Package pq_arb_pkg holds:
  - op encodings OP_NOP, OP_PUSH, OP_POP, OP_TOP;
  - the state enum (IDLE, PUSH, POP_WAIT, TOP_WAIT, RESP);
  - the response-error localparams.
- One sub-module, rr_arbiter (parameter N): pure round-robin grant.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once. The FSM, counters and queue sequencing stay in the top module.

Test Plan:
- Reset then single client: client0 PUSHes 5, 9, 3, then POPs three times. Required: responses 9, 5, 3 with rsp_err=0; occupancy goes 3→0.
- All 4 clients assert PUSH at once with data 10, 20, 30, 40. Required: grants in order 0, 1, 2, 3, one request per cycle in IDLE; occupancy=4; then a TOP returns 40 with occupancy still 4.
- POP on an empty queue right after reset. Required: rsp_valid within 2 cycles, rsp_err=1, rsp_data=0; pq_op never equals 10.
- Fill to PQ_DEPTH=8, then one more PUSH of 7. Required: rsp_err=1, pq_valid_in never asserted, occupancy stays 8.
- Hold the model queue's pq_valid_out low during a POP. Required: after TIMEOUT=32 cycles, rsp_err=1 and occupancy is unchanged.
- Assert reset during POP_WAIT. Required: all outputs go to 0 immediately, no rsp_valid pulse, occupancy=0, and the next request after reset is granted to client0.
